// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the default
// operand width.
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } adder_state_t;

endpackage : adder_pkg

// File: rtl/full_adder_cell.sv
// Combinational full adder built from two half adders. The second stage adds
// the carry-in, and the two partial carries are ORed together.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha_ab (
    .a (a),
    .b (b),
    .s (w_s0),
    .c (w_c0)
  );

  half_adder u_ha_ci (
    .a (w_s0),
    .b (ci),
    .s (s),
    .c (w_c1)
  );

  // The two partial carries can never both be high, so OR is exact.
  assign co = w_c0 | w_c1;

endmodule : full_adder_cell

// File: rtl/half_adder.sv
// One-bit half adder: sum is the XOR of the inputs, carry is the AND.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/serial_adder.sv
// Bit-serial adder that processes the operands LSB-first, one bit per clock, through a single full-adder cell.
// Operands and results are transferred over valid/ready handshakes.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  adder_state_t     r_state;
  adder_state_t     w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_release;
  logic w_last;
  logic w_bit_sum;
  logic w_bit_carry;

  assign w_accept  = (r_state == IDLE)  && in_valid;
  assign w_release = (r_state == DONE)  && out_ready;
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_BIT);

  full_adder_cell u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_bit_sum),
    .co (w_bit_carry)
  );

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values, regardless of the order of the statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so that no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_next = SHIFT;
      SHIFT:   if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      // Each new bit enters at the MSB. After WIDTH shifts, bit 0 lands at the LSB.
      r_sum   <= {w_bit_sum, r_sum[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_bit_carry;
      r_cnt   <= r_cnt + CNT_W'(1);
    end else if (w_release) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end
  end

  // Handshake and result outputs depend only on registered state.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = (r_state == DONE) ? r_sum : '0;
  assign cout      = (r_state == DONE) ? r_carry : 1'b0;

endmodule : serial_adder
